wbs_iic_attach_mc: RTL and testbench

Wishbone slave front-end for a bank of C_NUM_CH independent IIC controller cores. Each channel has an op-FIFO push port, an RX-FIFO pop port, sticky status, control and FIFO reset. RX pops go through a wait-stated read FSM, so returned data is the popped byte. A registered, maskable interrupt summarises channel faults to the processor.

---
 rtl/wbs_iic_attach_mc.sv | 259 +++++++++++++++++++++++++
 tb/tb_wbs_iic_attach_mc.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wbs_iic_attach_mc.sv
// Wishbone slave front-end for a bank of IIC controller channels.
// Each channel has: an op-FIFO push port, an RX-FIFO pop port, sticky status, control bits and a FIFO reset.
// RX pops go through a wait-stated read FSM (IDLE -> POP -> CAPT -> ACK), so the returned word is the popped byte.
// Bus handshake: a request is taken when cyc & stb are high, the address is inside the window, no ack is
// pending and the FSM is idle. It is answered by exactly one ack cycle. RX pops that are abandoned
// (cyc or stb dropped) finish silently and record an abort.
module wbs_iic_attach_mc #(
   parameter logic [31:0] C_BASEADDR = 32'h0000_0000,
   parameter logic [31:0] C_HIGHADDR = 32'h0000_FFFF,
   parameter int          C_NUM_CH   = 4,
   parameter int          C_OP_WIDTH = 12,
   parameter int          C_RX_WIDTH = 8
) (
   input  logic                           wbs_clk_i,
   input  logic                           wbs_rst_i,
   input  logic                           wbs_we_i,
   input  logic                           wbs_cyc_i,
   input  logic                           wbs_stb_i,
   input  logic [0:3]                     wbs_sel_i,
   input  logic [0:31]                    wbs_dat_i,
   input  logic [0:31]                    wbs_adr_i,
   output logic [0:31]                    wbs_dat_o,
   output logic                           wbs_ack_o,
   output logic [C_NUM_CH-1:0]            op_fifo_wr_en,
   output logic [C_OP_WIDTH-1:0]          op_fifo_wr_data,
   input  logic [C_NUM_CH-1:0]            op_fifo_empty,
   input  logic [C_NUM_CH-1:0]            op_fifo_full,
   input  logic [C_NUM_CH-1:0]            op_fifo_over,
   output logic [C_NUM_CH-1:0]            rx_fifo_rd_en,
   input  logic [C_NUM_CH*C_RX_WIDTH-1:0] rx_fifo_rd_data,
   input  logic [C_NUM_CH-1:0]            rx_fifo_empty,
   input  logic [C_NUM_CH-1:0]            rx_fifo_full,
   input  logic [C_NUM_CH-1:0]            rx_fifo_over,
   output logic [C_NUM_CH-1:0]            fifo_rst,
   output logic [C_NUM_CH-1:0]            op_fifo_block,
   input  logic [C_NUM_CH-1:0]            op_error,
   output logic                           irq_o
);

   typedef enum logic [1:0] {S_IDLE, S_POP, S_CAPT, S_ACK} state_t;

   // Sticky bit positions inside sticky_q[k].
   localparam int ST_RX_OVER  = 0;
   localparam int ST_RX_UNDER = 1;
   localparam int ST_OP_OVER  = 2;
   localparam int ST_OP_DROP  = 3;
   localparam int ST_OP_ERROR = 4;
   localparam int ST_ABORT    = 5;

   state_t                       state_q, state_d;
   logic [2:0]                   ch_q, ch_d;
   logic                         ack_q, ack_d;
   logic                         abort_pend_q, abort_pend_d;
   logic [31:0]                  rdata_q, rdata_d;
   logic [C_NUM_CH-1:0]          wr_en_q, wr_en_d;
   logic [C_NUM_CH-1:0]          frst_q, frst_d;
   logic [C_OP_WIDTH-1:0]        wr_data_q, wr_data_d;
   logic [C_NUM_CH-1:0][5:0]     sticky_q, sticky_d;
   logic [C_NUM_CH-1:0][1:0]     ctrl_q, ctrl_d;
   logic                         irq_q, irq_d;

   // Bus fields as ordinary LSB-0 values (the port vectors are MSB-0 numbered).
   logic [31:0] adr, dat, local_adr;
   logic [3:0]  sel;
   logic [2:0]  req_ch;
   logic [1:0]  req_reg;
   logic        in_range, bus_live, request, ch_ok;

   assign adr       = wbs_adr_i;
   assign dat       = wbs_dat_i;
   assign sel       = wbs_sel_i;
   assign local_adr = adr - C_BASEADDR;
   // An address below the base wraps to a large offset, so one compare covers both window bounds.
   assign in_range  = (local_adr <= (C_HIGHADDR - C_BASEADDR));
   assign req_ch    = local_adr[6:4];
   assign req_reg   = local_adr[3:2];
   assign bus_live  = wbs_cyc_i & wbs_stb_i;
   assign request   = in_range & bus_live & ~ack_q & (state_q == S_IDLE);
   assign ch_ok     = ({29'd0, req_ch} < 32'(C_NUM_CH));

   logic [C_NUM_CH-1:0]      req_oh, cap_oh;
   logic                     cur_op_full, cur_rx_empty;
   logic [9:0]               cur_status;
   logic [1:0]               cur_ctrl;
   logic [C_RX_WIDTH-1:0]    cur_rx_data;
   logic [C_NUM_CH-1:0]      ev_under, ev_drop, ev_abort;
   logic [C_NUM_CH-1:0][5:0] clr;

   // Per-channel views: the addressed channel at request time and the latched channel for the pop.
   always_comb begin
      req_oh       = '0;
      cap_oh       = '0;
      cur_op_full  = 1'b0;
      cur_rx_empty = 1'b0;
      cur_status   = '0;
      cur_ctrl     = '0;
      cur_rx_data  = '0;
      for (int k = 0; k < C_NUM_CH; k++) begin
         if (req_ch == 3'(k)) begin
            req_oh[k]    = 1'b1;
            cur_op_full  = op_fifo_full[k];
            cur_rx_empty = rx_fifo_empty[k];
            cur_status   = {sticky_q[k][5:2], op_fifo_full[k], op_fifo_empty[k],
                            sticky_q[k][1:0], rx_fifo_full[k], rx_fifo_empty[k]};
            cur_ctrl     = ctrl_q[k];
         end
         if (ch_q == 3'(k)) begin
            cap_oh[k]   = 1'b1;
            cur_rx_data = rx_fifo_rd_data[k*C_RX_WIDTH +: C_RX_WIDTH];
         end
      end
   end

   // Access FSM: decode, register side effects for the ack cycle, sequence RX pops.
   always_comb begin
      state_d      = state_q;
      ch_d         = ch_q;
      ack_d        = 1'b0;
      abort_pend_d = abort_pend_q;
      rdata_d      = '0;
      wr_en_d      = '0;
      frst_d       = '0;
      wr_data_d    = wr_data_q;
      ctrl_d       = ctrl_q;
      ev_under     = '0;
      ev_drop      = '0;
      ev_abort     = '0;
      clr          = '0;
      unique case (state_q)
         S_IDLE: begin
            if (request) begin
               ch_d         = req_ch;
               abort_pend_d = 1'b0;
               state_d      = S_ACK;
               ack_d        = 1'b1;
               if (ch_ok) begin
                  unique case (req_reg)
                     2'd0: begin
                        if (wbs_we_i && sel[0]) begin
                           if (!cur_op_full) begin
                              wr_en_d   = req_oh;
                              wr_data_d = dat[C_OP_WIDTH-1:0];
                           end else begin
                              ev_drop = req_oh;
                           end
                        end
                     end
                     2'd1: begin
                        if (!wbs_we_i) begin
                           if (!cur_rx_empty) begin
                              state_d = S_POP;
                              ack_d   = 1'b0;
                           end else begin
                              ev_under = req_oh;
                           end
                        end
                     end
                     2'd2: begin
                        if (wbs_we_i) begin
                           for (int k = 0; k < C_NUM_CH; k++) begin
                              if (req_oh[k]) clr[k] = {dat[9], dat[8], dat[7], dat[6], dat[3], dat[2]};
                           end
                           if (dat[31]) frst_d = req_oh;
                        end else begin
                           rdata_d = {22'd0, cur_status};
                        end
                     end
                     default: begin
                        if (wbs_we_i) begin
                           if (sel[0]) begin
                              for (int k = 0; k < C_NUM_CH; k++) begin
                                 if (req_oh[k]) ctrl_d[k] = dat[1:0];
                              end
                           end
                        end else begin
                           rdata_d = {30'd0, cur_ctrl};
                        end
                     end
                  endcase
               end
            end
         end
         S_POP: begin
            state_d = S_CAPT;
            if (!bus_live) abort_pend_d = 1'b1;
         end
         S_CAPT: begin
            if (abort_pend_q || !bus_live) begin
               // Master gave up: the popped word is discarded and no ack is given.
               state_d  = S_IDLE;
               ev_abort = cap_oh;
            end else begin
               state_d = S_ACK;
               ack_d   = 1'b1;
               rdata_d = 32'(cur_rx_data);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Sticky status (set beats clear) and the interrupt summary, evaluated every cycle.
   always_comb begin
      sticky_d = sticky_q;
      irq_d    = 1'b0;
      for (int k = 0; k < C_NUM_CH; k++) begin
         sticky_d[k] = (sticky_q[k] & ~clr[k]) |
                       {ev_abort[k], op_error[k], ev_drop[k], op_fifo_over[k], ev_under[k], rx_fifo_over[k]};
         irq_d       = irq_d | (ctrl_q[k][1] & (|sticky_q[k]));
      end
   end

   // State and output registers.
   always_ff @(posedge wbs_clk_i or posedge wbs_rst_i) begin
      if (wbs_rst_i) begin
         state_q      <= S_IDLE;
         ch_q         <= '0;
         ack_q        <= 1'b0;
         abort_pend_q <= 1'b0;
         rdata_q      <= '0;
         wr_en_q      <= '0;
         frst_q       <= '0;
         wr_data_q    <= '0;
         sticky_q     <= '0;
         ctrl_q       <= '0;
         irq_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         ch_q         <= ch_d;
         ack_q        <= ack_d;
         abort_pend_q <= abort_pend_d;
         rdata_q      <= rdata_d;
         wr_en_q      <= wr_en_d;
         frst_q       <= frst_d;
         wr_data_q    <= wr_data_d;
         sticky_q     <= sticky_d;
         ctrl_q       <= ctrl_d;
         irq_q        <= irq_d;
      end
   end

   assign wbs_ack_o       = ack_q;
   assign wbs_dat_o       = ack_q ? rdata_q : 32'd0;
   assign op_fifo_wr_en   = wr_en_q;
   assign op_fifo_wr_data = wr_data_q;
   assign rx_fifo_rd_en   = (state_q == S_POP) ? cap_oh : '0;
   assign fifo_rst        = frst_q;
   assign irq_o           = irq_q;
   always_comb begin
      op_fifo_block = '0;
      for (int k = 0; k < C_NUM_CH; k++) op_fifo_block[k] = ctrl_q[k][0];
   end

   logic unused_bits;
   assign unused_bits = ^{dat[30:10], sel[3:1]};

endmodule

// File: tb/tb_wbs_iic_attach_mc.sv
// Bench for wbs_iic_attach_mc: a table of single bus accesses plus hand-written multi-cycle sequences.
module tb_wbs_iic_attach_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i, cyc_i, stb_i;
  logic [0:3]  sel_i;
  logic [0:31] dat_i, adr_i, dat_o;
  logic        ack;
  logic [3:0]  wr_en, op_empty, op_full, op_over;
  logic [11:0] wr_data;
  logic [3:0]  rd_en, rx_empty, rx_full, rx_over;
  logic [31:0] rx_data;
  logic [3:0]  frst, block, op_error;
  logic        irq;

  int total = 0;
  int bad   = 0;

  wbs_iic_attach_mc dut (
    .wbs_clk_i(clk), .wbs_rst_i(rst), .wbs_we_i(we_i), .wbs_cyc_i(cyc_i), .wbs_stb_i(stb_i),
    .wbs_sel_i(sel_i), .wbs_dat_i(dat_i), .wbs_adr_i(adr_i), .wbs_dat_o(dat_o), .wbs_ack_o(ack),
    .op_fifo_wr_en(wr_en), .op_fifo_wr_data(wr_data), .op_fifo_empty(op_empty),
    .op_fifo_full(op_full), .op_fifo_over(op_over), .rx_fifo_rd_en(rd_en),
    .rx_fifo_rd_data(rx_data), .rx_fifo_empty(rx_empty), .rx_fifo_full(rx_full),
    .rx_fifo_over(rx_over), .fifo_rst(frst), .op_fifo_block(block), .op_error(op_error),
    .irq_o(irq)
  );

  // clock
  always #5 clk = ~clk;

  // RX FIFO model: data is valid the cycle after a pop, garbage otherwise.
  logic [7:0] rx_mem [4];
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) rx_data[k*8 +: 8] <= rd_en[k] ? rx_mem[k] : 8'hEE;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Results of the last bus access.
  int          x_lat, x_rd_cnt;
  logic [31:0] x_rd;
  logic [3:0]  x_wr_ack, x_frst_ack, x_rd_first, x_wr_seen;
  logic [11:0] x_wd_ack;
  logic        x_nz_idle;

  // driver: one access, waits up to 8 cycles for ack
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    x_lat = -1; x_rd = '0; x_wr_ack = '0; x_frst_ack = '0; x_rd_first = '0;
    x_wr_seen = '0; x_wd_ack = '0; x_nz_idle = 1'b0; x_rd_cnt = 0;
    @(posedge clk); #1;
    we_i = w; adr_i = a; dat_i = d; sel_i = s; cyc_i = 1'b1; stb_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i == 1) x_rd_first = rd_en;
      if (rd_en != 4'd0) x_rd_cnt++;
      x_wr_seen = x_wr_seen | wr_en;
      if (ack) begin
        x_lat = i; x_rd = dat_o; x_wr_ack = wr_en; x_frst_ack = frst; x_wd_ack = wr_data;
        break;
      end else if (dat_o != 32'd0) begin
        x_nz_idle = 1'b1;
      end
    end
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          exp_lat;
    logic [31:0] exp_rd;
    logic [3:0]  exp_wr;
    logic [3:0]  exp_frst;
    logic        chk_wd;
    logic [11:0] exp_wd;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int lat, input logic [31:0] rd, input logic [3:0] wr, input logic [3:0] fr,
                         input logic cw, input logic [11:0] wd);
    vec_t v;
    v.we = w; v.adr = a; v.dat = d; v.sel = s; v.exp_lat = lat; v.exp_rd = rd;
    v.exp_wr = wr; v.exp_frst = fr; v.chk_wd = cw; v.exp_wd = wd;
    vq.push_back(v);
  endtask

  logic ab_ack;

  initial begin
    // ---- table ----
    add_vec(1, 32'h20, 32'h0000_0ABC, 4'hF, 1, 0, 4'b0100, 0, 1, 12'hABC); // OP ch2
    add_vec(1, 32'h00, 32'h0000_0123, 4'hE, 1, 0, 4'b0000, 0, 0, 12'h0);   // OP ch0, LSB lane off
    add_vec(1, 32'h10, 32'h1234_5FFF, 4'h1, 1, 0, 4'b0010, 0, 1, 12'hFFF); // OP ch1, LSB lane only
    add_vec(0, 32'h00, 32'h0,         4'hF, 1, 0, 4'b0000, 0, 0, 12'h0);   // OP read -> 0
    add_vec(1, 32'h0C, 32'h1,         4'hF, 1, 0, 4'b0000, 0, 0, 12'h0);   // CTRL ch0 = block
    add_vec(0, 32'h0C, 32'h0,         4'hF, 1, 1, 4'b0000, 0, 0, 12'h0);   // CTRL ch0 read
    add_vec(1, 32'h1C, 32'h3,         4'hE, 1, 0, 4'b0000, 0, 0, 12'h0);   // CTRL ch1, lane off
    add_vec(0, 32'h1C, 32'h0,         4'hF, 1, 0, 4'b0000, 0, 0, 12'h0);   // CTRL ch1 unchanged
    add_vec(0, 32'h40, 32'h0,         4'hF, 1, 0, 4'b0000, 0, 0, 12'h0);   // ch4 out of range
    add_vec(1, 32'h50, 32'h55,        4'hF, 1, 0, 4'b0000, 0, 0, 12'h0);   // ch5 OP write ignored
    add_vec(0, 32'h7C, 32'h0,         4'hF, 1, 0, 4'b0000, 0, 0, 12'h0);   // ch7 CTRL read
    add_vec(0, 32'h38, 32'h0,         4'hF, 1, 32'h011, 4'b0000, 0, 0, 12'h0); // STATUS ch3
    add_vec(0, 32'h0001_0000, 32'h0,  4'hF, -1, 0, 4'b0000, 0, 0, 12'h0);  // outside window
    add_vec(1, 32'h24, 32'hFF,        4'hF, 1, 0, 4'b0000, 0, 0, 12'h0);   // RX write: ack only
    add_vec(1, 32'h08, 32'h8000_0000, 4'hF, 1, 0, 4'b0000, 4'b0001, 0, 12'h0); // fifo_rst ch0

    // ---- clock/reset ----
    rst = 1'b1; we_i = 0; cyc_i = 0; stb_i = 0; sel_i = 0; dat_i = 0; adr_i = 0;
    op_empty = 4'hF; op_full = 0; op_over = 0; rx_empty = 4'hF; rx_full = 0; rx_over = 0; op_error = 0;
    for (int k = 0; k < 4; k++) rx_mem[k] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {ack, dat_o, wr_en, wr_data, rd_en, frst, block, irq}, 64'd0);
    rst = 1'b0;

    // ---- reset during POP ----
    rx_empty[0] = 1'b0; rx_mem[0] = 8'h33;
    @(posedge clk); #1;
    cyc_i = 1; stb_i = 1; we_i = 0; adr_i = 32'h04; sel_i = 4'hF;
    @(posedge clk); #1;
    check("midpop_rd_en", rd_en, 4'b0001);
    rst = 1'b1; #1;
    check("midpop_reset_out", {ack, dat_o, wr_en, rd_en, frst, block, irq}, 64'd0);
    cyc_i = 0; stb_i = 0; rx_empty[0] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    xfer(0, 32'h08, 0, 4'hF);
    check("midpop_status_lat", 64'(x_lat), 64'd1);
    check("midpop_status", x_rd, 32'h011);

    // ---- table ----
    foreach (vq[n]) begin
      xfer(vq[n].we, vq[n].adr, vq[n].dat, vq[n].sel);
      check($sformatf("vec%0d_lat", n), 64'(x_lat), 64'(vq[n].exp_lat));
      check($sformatf("vec%0d_rdata", n), x_rd, vq[n].exp_rd);
      check($sformatf("vec%0d_wr_en", n), x_wr_seen, vq[n].exp_wr);
      check($sformatf("vec%0d_fifo_rst", n), x_frst_ack, vq[n].exp_frst);
      check($sformatf("vec%0d_dat_idle", n), x_nz_idle, 1'b0);
      if (vq[n].chk_wd) check($sformatf("vec%0d_wr_data", n), x_wd_ack, vq[n].exp_wd);
      @(posedge clk); #1;
      check($sformatf("vec%0d_strobes_after", n), {ack, wr_en, frst, rd_en}, 13'd0);
    end
    check("block_ch0", block, 4'b0001);
    check("op_wr_at_ack", x_wr_ack, 4'b0000);

    // ---- RX read with data ----
    rx_empty[1] = 1'b0; rx_mem[1] = 8'h5A;
    xfer(0, 32'h14, 0, 4'hF);
    rx_empty[1] = 1'b1;
    check("rx_lat", 64'(x_lat), 64'd3);
    check("rx_data", x_rd, 32'h0000_005A);
    check("rx_rd_en_first", x_rd_first, 4'b0010);
    check("rx_rd_en_cycles", 64'(x_rd_cnt), 64'd1);
    check("rx_dat_idle", x_nz_idle, 1'b0);

    // ---- RX underflow and interrupt ----
    xfer(1, 32'h1C, 32'h2, 4'hF);
    xfer(0, 32'h14, 0, 4'hF);
    check("under_lat", 64'(x_lat), 64'd1);
    check("under_data", x_rd, 32'd0);
    check("under_rd_en", 64'(x_rd_cnt), 64'd0);
    check("irq_not_yet", irq, 1'b0);
    @(posedge clk); #1;
    check("irq_rise", irq, 1'b1);
    xfer(0, 32'h18, 0, 4'hF);
    check("under_status", x_rd, 32'h019);
    xfer(1, 32'h18, 32'h8, 4'hF);
    check("irq_hold_at_clear", irq, 1'b1);
    @(posedge clk); #1;
    check("irq_fall", irq, 1'b0);
    xfer(0, 32'h18, 0, 4'hF);
    check("under_cleared", x_rd, 32'h011);

    // ---- OP full drop and fifo reset ----
    op_full[3] = 1'b1;
    xfer(1, 32'h30, 32'h77, 4'hF);
    check("drop_lat", 64'(x_lat), 64'd1);
    check("drop_no_wr", x_wr_seen, 4'b0000);
    xfer(0, 32'h38, 0, 4'hF);
    check("drop_status", x_rd, 32'h0B1);
    xfer(1, 32'h38, 32'h8000_0000, 4'hF);
    check("frst_ch3", x_frst_ack, 4'b1000);
    @(posedge clk); #1;
    check("frst_one_cycle", frst, 4'b0000);
    xfer(0, 32'h38, 0, 4'hF);
    check("frst_sticky_kept", x_rd, 32'h0B1);
    op_full[3] = 1'b0;
    xfer(1, 32'h38, 32'h80, 4'hF);
    xfer(0, 32'h38, 0, 4'hF);
    check("drop_cleared", x_rd, 32'h011);

    // ---- abort during CAPT ----
    rx_empty[0] = 1'b0; rx_mem[0] = 8'h77;
    @(posedge clk); #1;
    cyc_i = 1; stb_i = 1; we_i = 0; adr_i = 32'h04; sel_i = 4'hF;
    @(posedge clk); #1;
    ab_ack = ack;
    @(posedge clk); #1;
    ab_ack = ab_ack | ack;
    stb_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      ab_ack = ab_ack | ack;
    end
    cyc_i = 1'b0; rx_empty[0] = 1'b1;
    check("abort_no_ack", ab_ack, 1'b0);
    xfer(0, 32'h08, 0, 4'hF);
    check("abort_status", x_rd, 32'h211);

    // ---- set beats clear ----
    @(posedge clk); #1; op_error[0] = 1'b1;
    @(posedge clk); #1; op_error[0] = 1'b0;
    xfer(0, 32'h08, 0, 4'hF);
    check("err_status", x_rd, 32'h311);
    @(posedge clk); #1;
    cyc_i = 1; stb_i = 1; we_i = 1; adr_i = 32'h08; dat_i = 32'h100; sel_i = 4'hF; op_error[0] = 1'b1;
    @(posedge clk); #1;
    op_error[0] = 1'b0;
    check("setclr_ack", ack, 1'b1);
    cyc_i = 0; stb_i = 0; we_i = 0;
    xfer(0, 32'h08, 0, 4'hF);
    check("set_wins", x_rd, 32'h311);
    xfer(1, 32'h08, 32'h300, 4'h0);
    xfer(0, 32'h08, 0, 4'hF);
    check("clear_sel_ignored", x_rd, 32'h011);
    check("irq_final", irq, 1'b0);

    // ---- report ----
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
